// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle add/sub/mul/div/mod ALU with valid/ready handshakes
`timescale 1ns/1ps
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    input  logic [3:0]           op_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   R,
    output logic                 overflow,
    output logic                 div_zero,
    output logic                 bad_op
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_MOD = 4'b0001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [3:0]           op_q;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     dvd;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;

    assign in_ready = (state == IDLE) && rst_n;

    // Add/sub: overflow is carry into MSB xor carry out of MSB.
    logic               is_sub;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   low_sum;
    logic               add_ovf;

    assign is_sub   = (op_code == OP_SUB);
    assign addend   = is_sub ? ~inputB : inputB;
    assign sum_full = {1'b0, inputA} + {1'b0, addend} + (WIDTH+1)'(is_sub);
    assign low_sum  = {1'b0, inputA[WIDTH-2:0]} + {1'b0, addend[WIDTH-2:0]} + WIDTH'(is_sub);
    assign add_ovf  = low_sum[WIDTH-1] ^ sum_full[WIDTH];

    logic [2*WIDTH-1:0] acc_next;
    assign acc_next = mplier[0] ? acc + mcand : acc;

    // One restoring-division step: the top bit of diff is the borrow.
    logic [WIDTH:0]     part;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign part     = {rem, dvd[WIDTH-1]};
    assign diff     = part - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], q_bit};

    logic last_iter;
    assign last_iter = (cnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            divisor   <= '0;
            dvd       <= '0;
            rem       <= '0;
            quo       <= '0;
            R         <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
            bad_op    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_code;
                        cnt      <= '0;
                        acc      <= '0;
                        rem      <= '0;
                        quo      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, inputA};
                        mplier   <= inputB;
                        dvd      <= inputA;
                        divisor  <= inputB;
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                        bad_op   <= 1'b0;
                        case (op_code)
                            OP_ADD, OP_SUB: begin
                                R         <= {{WIDTH{sum_full[WIDTH-1]}}, sum_full[WIDTH-1:0]};
                                overflow  <= add_ovf;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            OP_MUL: state <= CALC;
                            OP_DIV, OP_MOD: begin
                                if (inputB == '0) begin
                                    R         <= '1;
                                    div_zero  <= 1'b1;
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    state <= CALC;
                                end
                            end
                            default: begin
                                R         <= '0;
                                bad_op    <= 1'b1;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        dvd <= dvd << 1;
                    end
                    if (last_iter) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        if (op_q == OP_MUL)
                            R <= acc_next;
                        else if (op_q == OP_DIV)
                            R <= {{WIDTH{1'b0}}, quo_next};
                        else
                            R <= {{WIDTH{1'b0}}, rem_next};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
